wb_register_file: RTL and testbench
===================================

# wb_register_file

Writeback stage and architectural register file for the 5-stage pipeline. It consumes the MEM/WB pipeline register outputs, selects the writeback value, and commits it to a 32×32-bit register file on the clock edge. It serves two combinational read ports to the ID stage, with write-through bypass so that a same-cycle writeback is visible to decode. It also keeps a committed-write counter for the debug/perf path.

## Interface
Parameters:
- `SP_INIT`, 32'h0000_07FC, reset value of register $29 (sp); every other register resets to 0.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_reg_write`  in  1  writeback enable, from MEM/WB.
- `i_mem_to_reg`  in  2  writeback source select, from MEM/WB.
- `i_write_register`  in  5  destination register index.
- `i_result`  in  32  ALU result.
- `i_mem_read_data`  in  32  load data.
- `i_pc_4`  in  32  PC+4, the link value for jal/jalr.
- `i_imm_ext_out`  in  32  extended immediate, for lui.
- `i_rs_addr`  in  5  read port 1 index, from ID.
- `i_rt_addr`  in  5  read port 2 index, from ID.
- `o_rs_data`  out  32  read port 1 data (combinational).
- `o_rt_data`  out  32  read port 2 data (combinational).
- `o_wb_data`  out  32  selected writeback value (combinational), also fed to the forwarding muxes.
- `o_wb_count`  out  32  number of committed register writes since reset.

## Operation
- Writeback select (`o_wb_data`):
  - `i_mem_to_reg` = 0 → `i_result`.
  - 1 → `i_mem_read_data`.
  - 2 → `i_pc_4`.
  - 3 → `i_imm_ext_out`.
- Commit condition: `i_reg_write`=1, `i_write_register`≠0 and `reset`=0. On a commit, `regs[i_write_register]` ← `o_wb_data` at the rising edge.
- Register $0 is hardwired to 0:
  - Writes to it are discarded.
  - Reads of index 0 always return 0, including under the bypass condition.
- Read ports:
  - `o_rs_data` = 0 if `i_rs_addr`=0.
  - Otherwise `o_rs_data` = `o_wb_data` if the commit condition holds and `i_write_register`==`i_rs_addr`.
  - Otherwise `o_rs_data` = `regs[i_rs_addr]`.
  - `o_rt_data` follows the same rule using `i_rt_addr`.
- Both read ports may address the same register, and may both match the write index; each then returns `o_wb_data`.
- `o_wb_count` increments by 1 on every commit and wraps from 32'hFFFF_FFFF to 0. Discarded writes (to $0, or with `i_reg_write`=0) do not count.
- Reset (synchronous, highest priority):
  - All registers go to 0, except $29, which goes to `SP_INIT`.
  - `o_wb_count` goes to 0.
  - Any write presented in the same cycle is discarded and not counted.
  - While `reset` is high, the bypass is disabled and the read ports return register contents, i.e. the reset values from the cycle after reset is first sampled.

## Timing
- Write latency: 1 cycle. A value presented in cycle N is stored at the edge ending cycle N and is readable from the array in cycle N+1.
- Bypass latency: 0 cycles. The value is visible on the read ports in cycle N itself, which lets a producer in WB and a consumer in ID overlap without a stall.
- `o_wb_data`, `o_rs_data` and `o_rt_data` are purely combinational from current inputs and state; there is no registered output delay.
- `o_wb_count` is registered: a commit in cycle N appears in the count in cycle N+1.
- Reset asserted mid-stream takes effect at the next edge. Deasserting reset allows commits from the first cycle in which `reset`=0.
- No handshake: the block accepts one writeback every cycle and never stalls.

## Test plan
- Reset then read all 32 indices → 0 everywhere except $29 = 32'h0000_07FC; `o_wb_count`=0.
- Write $8=32'hDEAD_BEEF with mem_to_reg=0, then one write each for sources 1/2/3 to $9/$31/$10 with distinct values → each register holds its selected source; `o_wb_count`=4.
- Write to $0 with value 32'h1234_5678 and `i_reg_write`=1, rs=0 → `o_rs_data`=0 in the same and the next cycle; `o_wb_count` unchanged.
- Same-cycle bypass: $5 holds 7; write $5=32'hCAFE_0001 while rs=rt=5 → both ports read 32'hCAFE_0001 in the write cycle and the cycle after.
- Bypass gating: set `i_reg_write`=0 with write index 5 and a different value, rs=5 → `o_rs_data` returns the stored value.
- Assert reset in the same cycle as a write of $3=32'hFFFF_FFFF → $3=0 afterwards and `o_wb_count`=0. Separately, preload the count to 32'hFFFF_FFFF via back-door force, do one commit → count = 0.

Source files
------------

// File: rtl/wb_register_file.sv
// Writeback stage and 32x32 architectural register file with write-through
// bypass to the two decode read ports, plus a committed-write counter.
module wb_register_file #(
    parameter logic [31:0] SP_INIT = 32'h0000_07FC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_reg_write,
    input  logic [1:0]  i_mem_to_reg,
    input  logic [4:0]  i_write_register,
    input  logic [31:0] i_result,
    input  logic [31:0] i_mem_read_data,
    input  logic [31:0] i_pc_4,
    input  logic [31:0] i_imm_ext_out,
    input  logic [4:0]  i_rs_addr,
    input  logic [4:0]  i_rt_addr,
    output logic [31:0] o_rs_data,
    output logic [31:0] o_rt_data,
    output logic [31:0] o_wb_data,
    output logic [31:0] o_wb_count
);

    logic [31:0] r_regs [32];
    logic [31:0] r_wb_count;
    logic [31:0] w_wb_data;
    logic        w_commit;

    // Index 0 reads as zero even when it matches a (discarded) write index.
    function automatic logic [31:0] read_port(
        input logic [4:0]  addr,
        input logic        commit,
        input logic [4:0]  waddr,
        input logic [31:0] wdata,
        input logic [31:0] stored
    );
        if (addr == 5'd0)
            return 32'd0;
        else if (commit && (waddr == addr))
            return wdata;
        else
            return stored;
    endfunction

    always_comb begin
        w_wb_data = i_result;
        unique case (i_mem_to_reg)
            2'd0: w_wb_data = i_result;
            2'd1: w_wb_data = i_mem_read_data;
            2'd2: w_wb_data = i_pc_4;
            2'd3: w_wb_data = i_imm_ext_out;
        endcase
    end

    // Reset gates the commit, which also disables the bypass while it is high.
    assign w_commit = i_reg_write && (i_write_register != 5'd0) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                r_regs[i] <= (i == 29) ? SP_INIT : 32'd0;
            r_wb_count <= 32'd0;
        end else if (w_commit) begin
            r_regs[i_write_register] <= w_wb_data;
            r_wb_count               <= r_wb_count + 32'd1;
        end
    end

    assign o_wb_data  = w_wb_data;
    assign o_wb_count = r_wb_count;
    assign o_rs_data  = read_port(i_rs_addr, w_commit, i_write_register, w_wb_data,
                                  r_regs[i_rs_addr]);
    assign o_rt_data  = read_port(i_rt_addr, w_commit, i_write_register, w_wb_data,
                                  r_regs[i_rt_addr]);

endmodule

// File: tb/tb_wb_register_file.sv
// Directed bench for wb_register_file: expected values are queued when the
// stimulus is driven and popped when the outputs are sampled.
module tb_wb_register_file;

    logic        clk;
    logic        reset;
    logic        i_reg_write;
    logic [1:0]  i_mem_to_reg;
    logic [4:0]  i_write_register;
    logic [31:0] i_result;
    logic [31:0] i_mem_read_data;
    logic [31:0] i_pc_4;
    logic [31:0] i_imm_ext_out;
    logic [4:0]  i_rs_addr;
    logic [4:0]  i_rt_addr;
    logic [31:0] o_rs_data;
    logic [31:0] o_rt_data;
    logic [31:0] o_wb_data;
    logic [31:0] o_wb_count;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    wb_register_file #(.SP_INIT(32'h0000_07FC)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_reg_write      (i_reg_write),
        .i_mem_to_reg     (i_mem_to_reg),
        .i_write_register (i_write_register),
        .i_result         (i_result),
        .i_mem_read_data  (i_mem_read_data),
        .i_pc_4           (i_pc_4),
        .i_imm_ext_out    (i_imm_ext_out),
        .i_rs_addr        (i_rs_addr),
        .i_rt_addr        (i_rt_addr),
        .o_rs_data        (o_rs_data),
        .o_rt_data        (o_rt_data),
        .o_wb_data        (o_wb_data),
        .o_wb_count       (o_wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=queued_entry", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Present one writeback/read cycle at the falling edge; outputs settle by +2.
    task automatic drive(input logic rw, input logic [1:0] sel, input logic [4:0] wr,
                         input logic [31:0] res, input logic [4:0] rs, input logic [4:0] rt);
        @(negedge clk);
        i_reg_write      = rw;
        i_mem_to_reg     = sel;
        i_write_register = wr;
        i_result         = res;
        i_rs_addr        = rs;
        i_rt_addr        = rt;
        #2;
    endtask

    initial begin
        reset            = 1'b1;
        i_reg_write      = 1'b0;
        i_mem_to_reg     = 2'd0;
        i_write_register = 5'd0;
        i_result         = 32'd0;
        i_mem_read_data  = 32'h1111_0009;
        i_pc_4           = 32'h0040_0024;
        i_imm_ext_out    = 32'hABCD_0000;
        i_rs_addr        = 5'd0;
        i_rt_addr        = 5'd0;
        repeat (2) @(posedge clk);

        // Reset state of every register on both ports, and the counter.
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 2'd0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            push($sformatf("reset_rs_%0d", i), (i == 29) ? 32'h0000_07FC : 32'd0);
            pop_check(o_rs_data);
            push($sformatf("reset_rt_%0d", 31 - i), (31 - i == 29) ? 32'h0000_07FC : 32'd0);
            pop_check(o_rt_data);
        end
        push("reset_count", 32'd0);
        pop_check(o_wb_count);

        // One write per writeback source.
        drive(1'b1, 2'd0, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0);
        push("wbsel0", 32'hDEAD_BEEF);
        pop_check(o_wb_data);
        drive(1'b1, 2'd1, 5'd9, 32'h0BAD_0BAD, 5'd0, 5'd0);
        push("wbsel1", 32'h1111_0009);
        pop_check(o_wb_data);
        drive(1'b1, 2'd2, 5'd31, 32'h0BAD_0BAD, 5'd0, 5'd0);
        push("wbsel2", 32'h0040_0024);
        pop_check(o_wb_data);
        drive(1'b1, 2'd3, 5'd10, 32'h0BAD_0BAD, 5'd0, 5'd0);
        push("wbsel3", 32'hABCD_0000);
        pop_check(o_wb_data);
        drive(1'b0, 2'd0, 5'd0, 32'd0, 5'd8, 5'd9);
        push("reg8", 32'hDEAD_BEEF);
        pop_check(o_rs_data);
        push("reg9", 32'h1111_0009);
        pop_check(o_rt_data);
        push("count4", 32'd4);
        pop_check(o_wb_count);
        drive(1'b0, 2'd0, 5'd0, 32'd0, 5'd31, 5'd10);
        push("reg31", 32'h0040_0024);
        pop_check(o_rs_data);
        push("reg10", 32'hABCD_0000);
        pop_check(o_rt_data);

        // Writes to $0 are discarded and never bypassed.
        drive(1'b1, 2'd0, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
        push("r0_same_rs", 32'd0);
        pop_check(o_rs_data);
        push("r0_same_rt", 32'd0);
        pop_check(o_rt_data);
        drive(1'b0, 2'd0, 5'd0, 32'd0, 5'd0, 5'd8);
        push("r0_next", 32'd0);
        pop_check(o_rs_data);
        push("r0_count", 32'd4);
        pop_check(o_wb_count);

        // Same-cycle bypass on both ports.
        drive(1'b1, 2'd0, 5'd5, 32'd7, 5'd0, 5'd0);
        drive(1'b0, 2'd0, 5'd0, 32'd0, 5'd5, 5'd5);
        push("reg5_seven", 32'd7);
        pop_check(o_rs_data);
        drive(1'b1, 2'd0, 5'd5, 32'hCAFE_0001, 5'd5, 5'd5);
        push("bypass_rs", 32'hCAFE_0001);
        pop_check(o_rs_data);
        push("bypass_rt", 32'hCAFE_0001);
        pop_check(o_rt_data);
        drive(1'b0, 2'd0, 5'd0, 32'd0, 5'd5, 5'd5);
        push("after_rs", 32'hCAFE_0001);
        pop_check(o_rs_data);
        push("after_rt", 32'hCAFE_0001);
        pop_check(o_rt_data);
        push("count6", 32'd6);
        pop_check(o_wb_count);

        // No bypass without reg_write.
        drive(1'b0, 2'd0, 5'd5, 32'h5555_5555, 5'd5, 5'd0);
        push("gated_rs", 32'hCAFE_0001);
        pop_check(o_rs_data);
        drive(1'b0, 2'd0, 5'd0, 32'd0, 5'd5, 5'd0);
        push("gated_stored", 32'hCAFE_0001);
        pop_check(o_rs_data);

        // Reset wins over a concurrent write, and disables the bypass.
        drive(1'b1, 2'd0, 5'd3, 32'h0000_0033, 5'd0, 5'd0);
        drive(1'b1, 2'd0, 5'd3, 32'hFFFF_FFFF, 5'd3, 5'd0);
        reset = 1'b1;
        #1;
        push("reset_nobypass", 32'h0000_0033);
        pop_check(o_rs_data);
        drive(1'b0, 2'd0, 5'd0, 32'd0, 5'd3, 5'd29);
        reset = 1'b0;
        #1;
        push("reg3_cleared", 32'd0);
        pop_check(o_rs_data);
        push("sp_restored", 32'h0000_07FC);
        pop_check(o_rt_data);
        push("count_cleared", 32'd0);
        pop_check(o_wb_count);

        // Counter wrap via back-door preload.
        @(negedge clk);
        force dut.r_wb_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_wb_count;
        #1;
        push("count_preload", 32'hFFFF_FFFF);
        pop_check(o_wb_count);
        drive(1'b1, 2'd0, 5'd1, 32'd1, 5'd1, 5'd0);
        drive(1'b0, 2'd0, 5'd0, 32'd0, 5'd1, 5'd0);
        push("count_wrap", 32'd0);
        pop_check(o_wb_count);
        push("reg1", 32'd1);
        pop_check(o_rs_data);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
